sipo7_deser: RTL and testbench

- Serial-in/parallel-out 7-bit deserializer macro for the schematic-capture behaviour library.
- It is the expanding counterpart to the 7-input reduction gates: it collects 7 serial bits on one input and presents them as a registered 7-bit word with a one-cycle valid strobe.
- It also provides a registered 7-input NAND flag of the word.
- Used wherever schematic designs fan one serial line out to 7 parallel lines.

---
 rtl/sipo7_pkg.sv | 24 ++
 rtl/sipo7_bitcnt.sv | 44 ++++
 rtl/sipo7_deser.sv | 94 +++++++++
 tb/tb_sipo7_deser.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo7_pkg.sv
// Shared constants for the 7-bit serial-in/parallel-out deserializer.
// Frame-state encoding is implied by the bit count.
package sipo7_pkg;

  localparam int FRAME_BITS     = 7;
  localparam int FRAME_BITS_PAR = 8;
  localparam int CNT_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

  function automatic state_e cnt_state(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)
      return ST_IDLE;
    else if (cnt == CNT_W'(FRAME_BITS))
      return ST_PAR;
    else
      return ST_SHIFT;
  endfunction

endpackage

// File: rtl/sipo7_bitcnt.sv
// Wrapping bit counter: counts accepted bits, flags the frame's last bit
// and keeps a registered "frame in progress" flag.
module sipo7_bitcnt
  import sipo7_pkg::*;
#(
  parameter logic [CNT_W-1:0] LAST = 3'd6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Clear beats enable, so a cleared final bit never produces a terminal count.
  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/sipo7_deser.sv
// 7-bit deserializer with valid strobe and registered NAND flag.
// Define SIPO7_PARITY_EN for 8-bit frames (7 data + 1 parity) with PERR.
module sipo7_deser
  import sipo7_pkg::*;
#(
  parameter int MSB_FIRST  = 0,
  parameter int ODD_PARITY = 0
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       SI,
  input  logic       SE,
  input  logic       SCLR,
  output logic [6:0] Q,
  output logic       DV,
  output logic       BUSY,
  output logic       ZN0,
  output logic       PERR
);

`ifdef SIPO7_PARITY_EN
  localparam int FRAME_LEN = FRAME_BITS_PAR;
  localparam bit PAR_EN    = 1'b1;
`else
  localparam int FRAME_LEN = FRAME_BITS;
  localparam bit PAR_EN    = 1'b0;
`endif

  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             busy;

  sipo7_bitcnt #(
    .LAST(CNT_W'(FRAME_LEN - 1))
  ) u_bitcnt (
    .clk_i (CK),
    .rst_ni(RN),
    .en_i  (SE),
    .clr_i (SCLR),
    .cnt_o (cnt),
    .tc_o  (done),
    .busy_o(busy)
  );

  logic [6:0] sr_q, sr_d;
  logic [6:0] q_q, q_d;
  logic       dv_q, zn0_q, perr_q;
  logic [6:0] shifted;
  logic [6:0] word;
  logic       par_err;

  assign shifted = (MSB_FIRST != 0) ? {sr_q[5:0], SI} : {SI, sr_q[6:1]};

`ifdef SIPO7_PARITY_EN
  // SI on the completing edge is the parity bit; data is already stored.
  assign word = sr_q;
`else
  assign word = shifted;
`endif

  assign par_err = (^sr_q ^ SI) != (ODD_PARITY != 0);

  always_comb begin
    sr_d = sr_q;
    if (SCLR || done)
      sr_d = '0;
    else if (SE && (cnt != CNT_W'(FRAME_BITS)))
      sr_d = shifted;
    q_d = done ? word : q_q;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sr_q   <= '0;
      q_q    <= '0;
      dv_q   <= 1'b0;
      zn0_q  <= 1'b1;
      perr_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      q_q    <= q_d;
      dv_q   <= done;
      zn0_q  <= ~&q_d;
      perr_q <= PAR_EN && done && par_err;
    end
  end

  assign Q    = q_q;
  assign DV   = dv_q;
  assign BUSY = busy;
  assign ZN0  = zn0_q;
  assign PERR = perr_q;

endmodule

// File: tb/tb_sipo7_deser.sv
// Scoreboard bench for sipo7_deser: stimulus pushes expected words, a
// negedge monitor pops and compares on every DV strobe.
module tb_sipo7_deser;

  typedef struct {
    logic [6:0] q;
    logic       zn;
    logic       perr;
    int         gap;
  } exp_t;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       SI = 1'b0;
  logic       SE = 1'b0;
  logic       SCLR = 1'b0;
  logic [6:0] Q;
  logic       DV, BUSY, ZN0, PERR;

  exp_t       exp_q[$];
  logic       exp_busy = 1'b0;
  bit         done = 1'b0;

  int         checks = 0;
  int         errors = 0;
  int         ncyc = 0;
  int         last_dv = 0;
  logic [6:0] q_model = 7'h00;
  logic       zn_model = 1'b1;

  always #5 CK = ~CK;

  sipo7_deser #(
    .MSB_FIRST (0),
    .ODD_PARITY(0)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .SI  (SI),
    .SE  (SE),
    .SCLR(SCLR),
    .Q   (Q),
    .DV  (DV),
    .BUSY(BUSY),
    .ZN0 (ZN0),
    .PERR(PERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, ncyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: the only process that compares or counts.
  always @(negedge CK) begin
    exp_t e;
    ncyc++;
    if (!RN) begin
      check("rst_q", 32'(Q), 32'h00);
      check("rst_dv", 32'(DV), 32'h0);
      check("rst_busy", 32'(BUSY), 32'h0);
      check("rst_zn0", 32'(ZN0), 32'h1);
      check("rst_perr", 32'(PERR), 32'h0);
      q_model  = 7'h00;
      zn_model = 1'b1;
    end else begin
      if (DV) begin
        if (exp_q.size() == 0) begin
          check("dv_unexpected", 32'(DV), 32'h0);
        end else begin
          e = exp_q.pop_front();
          $display("DV cycle %0d Q=0x%02h ZN0=%0b PERR=%0b (exp Q=0x%02h ZN0=%0b PERR=%0b)",
                   ncyc, Q, ZN0, PERR, e.q, e.zn, e.perr);
          check("dv_q", 32'(Q), 32'(e.q));
          check("dv_zn0", 32'(ZN0), 32'(e.zn));
          check("dv_perr", 32'(PERR), 32'(e.perr));
          if (e.gap != 0)
            check("dv_gap", 32'(ncyc - last_dv), 32'(e.gap));
          q_model  = e.q;
          zn_model = e.zn;
        end
        last_dv = ncyc;
      end else begin
        check("perr_idle", 32'(PERR), 32'h0);
      end
      check("q_hold", 32'(Q), 32'(q_model));
      check("zn0_hold", 32'(ZN0), 32'(zn_model));
      check("busy", 32'(BUSY), 32'(exp_busy));
    end
    if (done) begin
      check("pending_frames", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    if (ncyc > 5000) begin
      check("timeout", 32'(ncyc), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Sends seq[0] first; gap idle cycles after each bit except the last.
  task automatic send_bits(input logic [7:0] seq, input int n, input int gap, input bit last);
    for (int i = 0; i < n; i++) begin
      SE = 1'b1;
      SI = seq[i];
      tick(1);
      exp_busy = !(last && (i == n - 1));
      if (gap > 0 && i < n - 1) begin
        SE = 1'b0;
        tick(gap);
      end
    end
    SE = 1'b0;
    SI = 1'b0;
  endtask

  task automatic push(input logic [6:0] q, input logic zn, input logic perr, input int gap);
    exp_t e;
    e.q = q; e.zn = zn; e.perr = perr; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    RN = 1'b0;
    exp_busy = 1'b0;
    tick(2);
    RN = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(3);
    RN = 1'b1;
    tick(1);

`ifdef SIPO7_PARITY_EN
    // data 7'h07 (three ones) + parity 1 -> even total, no error
    push(7'h07, 1'b1, 1'b0, 0);
    send_bits({1'b1, 7'h07}, 8, 0, 1'b1);
    tick(2);
    // same data, parity 0 -> odd total, error
    push(7'h07, 1'b1, 1'b1, 0);
    send_bits({1'b0, 7'h07}, 8, 0, 1'b1);
    tick(2);
    // gapped all-ones data with parity 1 -> Q=7F, ZN0=0, PERR=0
    push(7'h7F, 1'b0, 1'b0, 0);
    send_bits({1'b1, 7'h7F}, 8, 2, 1'b1);
    tick(2);
    // reset mid-frame, then a clean frame
    send_bits(8'h05, 3, 0, 1'b0);
    pulse_reset();
    push(7'h13, 1'b1, 1'b0, 0);
    send_bits({1'b1, 7'h13}, 8, 0, 1'b1);
    tick(3);
`else
    // SI order 1,0,1,1,0,0,1 -> Q=7'h4D
    push(7'h4D, 1'b1, 1'b0, 0);
    send_bits(8'b0100_1101, 7, 0, 1'b1);
    tick(2);
    // seven 1s then seven 0s back to back, DVs 7 cycles apart
    push(7'h7F, 1'b0, 1'b0, 0);
    push(7'h00, 1'b1, 1'b0, 7);
    send_bits(8'h7F, 7, 0, 1'b1);
    send_bits(8'h00, 7, 0, 1'b1);
    tick(2);
    // 7'h2A with three idle cycles between bits
    push(7'h2A, 1'b1, 1'b0, 0);
    send_bits(8'h2A, 7, 3, 1'b1);
    tick(2);
    // SCLR on the 7th bit discards the frame; Q keeps 7'h2A
    send_bits(8'h3F, 6, 0, 1'b0);
    SE = 1'b1; SI = 1'b1; SCLR = 1'b1;
    tick(1);
    exp_busy = 1'b0;
    SE = 1'b0; SI = 1'b0; SCLR = 1'b0;
    tick(2);
    push(7'h55, 1'b1, 1'b0, 0);
    send_bits(8'h55, 7, 0, 1'b1);
    tick(2);
    // reset mid-frame, then a clean frame
    send_bits(8'h05, 3, 0, 1'b0);
    pulse_reset();
    push(7'h13, 1'b1, 1'b0, 0);
    send_bits(8'h13, 7, 1, 1'b1);
    tick(3);
`endif
    done = 1'b1;
  end

endmodule
